fp32_mul_seq: RTL and testbench

- Multi-cycle FP32 multiplier controller.
- Accepts an operand pair over a valid/ready handshake and unpacks it.
- Screens special operands; normal operands go through a 24-step iterative shift-add mantissa multiply.
- The 48-bit product is normalized and packed into an FP32 result, which is held until the consumer accepts it.

---
 rtl/fp32_pkg.sv | 44 ++++
 rtl/fp32_mant_iter_mul.sv | 52 +++++
 rtl/fp32_mul_seq.sv | 150 +++++++++++++++
 tb/tb_fp32_mul_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 field layout, constants, controller states and the unpacked-operand view
// used by the sequential FP32 multiplier.
package fp32_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 255;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int FRAC_MSB = 22;
   localparam int FRAC_W   = 23;
   localparam int EXP_W    = 8;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      NORM,
      HOLD
   } state_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [23:0]      mant;
      logic             is_zero;
      logic             is_inf;
      logic             is_nan;
   } fp32_unpacked_t;

   // Exponent 0 is treated as zero (no denormal inputs), so the hidden bit is always 1.
   function automatic fp32_unpacked_t fp32_unpack(input logic [31:0] x);
      fp32_unpacked_t u;
      u.sign    = x[SIGN_BIT];
      u.exp     = x[EXP_MSB:EXP_LSB];
      u.mant    = {1'b1, x[FRAC_MSB:0]};
      u.is_zero = (u.exp == '0);
      u.is_inf  = (u.exp == '1) && (x[FRAC_MSB:0] == '0);
      u.is_nan  = (u.exp == '1) && (x[FRAC_MSB:0] != '0);
      return u;
   endfunction

endpackage

// File: rtl/fp32_mant_iter_mul.sv
// Iterative shift-add significand multiplier: one multiplier bit per clock,
// MANT_W steps after start, with a combinational flag on the final step.
module fp32_mant_iter_mul #(
   parameter int MANT_W = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [MANT_W-1:0]     ma,
   input  logic [MANT_W-1:0]     mb,
   output logic [2*MANT_W-1:0]   acc,
   output logic                  last
);

   localparam int STEP_W = $clog2(MANT_W);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MANT_W - 1);

   logic [MANT_W-1:0] ma_r;
   logic [MANT_W-1:0] mb_r;
   logic [STEP_W-1:0] step;
   logic              active;

   // last is high during the cycle whose edge processes the final multiplier bit
   assign last = active && (step == LAST_STEP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ma_r   <= '0;
         mb_r   <= '0;
         acc    <= '0;
         step   <= '0;
         active <= 1'b0;
      end else if (start) begin
         ma_r   <= ma;
         mb_r   <= mb;
         acc    <= '0;
         step   <= '0;
         active <= 1'b1;
      end else if (active) begin
         if (mb_r[step]) begin
            acc <= acc + ({{MANT_W{1'b0}}, ma_r} << step);
         end
         if (last) begin
            step   <= '0;
            active <= 1'b0;
         end else begin
            step <= step + STEP_W'(1);
         end
      end
   end

endmodule

// File: rtl/fp32_mul_seq.sv
// Multi-cycle FP32 multiplier controller: handshake in, special-case screen,
// iterative significand multiply, truncating normalize/pack, result held until taken.
module fp32_mul_seq
   import fp32_pkg::*;
#(
   parameter int MANT_W = 24,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      a,
   input  logic [31:0]      b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      result,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   localparam int ACC_W = 2 * MANT_W;
   localparam logic signed [9:0] EXP_TOP = 10'(EXP_MAX);
   localparam logic signed [9:0] BIAS_S  = 10'(EXP_BIAS);

   state_t             state;
   state_t             next_state;
   fp32_unpacked_t     ua;
   fp32_unpacked_t     ub;
   logic               accept;
   logic               special;
   logic               start;
   logic               mul_last;
   logic               sign_in;
   logic [31:0]        special_res;
   logic [31:0]        norm_res;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   acc_n;
   logic               sign_r;
   logic signed [9:0]  exp_sum;
   logic signed [9:0]  exp_n;
   logic [9:0]         sh;
   logic [31:0]        result_r;
   logic [CNT_W-1:0]   cnt;

   assign ua      = fp32_unpack(a);
   assign ub      = fp32_unpack(b);
   assign sign_in = ua.sign ^ ub.sign;
   assign special = ua.is_nan | ub.is_nan | ua.is_inf | ub.is_inf | ua.is_zero | ub.is_zero;
   assign accept  = in_valid && in_ready;
   assign start   = accept && !special;

   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE);
   assign result    = result_r;
   assign done_cnt  = cnt;

   fp32_mant_iter_mul #(.MANT_W(MANT_W)) u_mant (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .ma    (ua.mant),
      .mb    (ub.mant),
      .acc   (acc),
      .last  (mul_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               next_state = special ? HOLD : MUL;
            end
         end
         MUL:     if (mul_last) next_state = NORM;
         NORM:    next_state = HOLD;
         HOLD:    if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NaN wins over everything, then inf*zero, then the infinities, then zeros
   always_comb begin
      special_res = {sign_in, 31'd0};
      if (ua.is_nan || ub.is_nan) begin
         special_res = QNAN;
      end else if ((ua.is_inf && ub.is_zero) || (ub.is_inf && ua.is_zero)) begin
         special_res = QNAN;
      end else if (ua.is_inf || ub.is_inf) begin
         special_res = {sign_in, 8'hFF, 23'd0};
      end
   end

   // Product of two [1,2) significands lies in [1,4); a set MSB means one extra exponent step
   always_comb begin
      acc_n = acc;
      exp_n = exp_sum;
      if (acc[ACC_W-1]) begin
         acc_n = acc >> 1;
         exp_n = exp_sum + 10'sd1;
      end
      sh = 10'sd1 - exp_n;
      if (exp_n >= EXP_TOP) begin
         norm_res = {sign_r, 8'hFF, 23'd0};
      end else if (exp_n <= 10'sd0) begin
         if (sh < 10'(ACC_W)) begin
            norm_res = {sign_r, 8'd0, FRAC_W'((acc_n >> sh) >> (MANT_W - 1))};
         end else begin
            norm_res = {sign_r, 31'd0};
         end
      end else begin
         norm_res = {sign_r, 8'(exp_n), FRAC_W'(acc_n >> (MANT_W - 1))};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign_r   <= 1'b0;
         exp_sum  <= '0;
         result_r <= '0;
         cnt      <= '0;
      end else begin
         if (accept) begin
            sign_r  <= sign_in;
            exp_sum <= $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - BIAS_S;
            if (special) begin
               result_r <= special_res;
            end
         end
         if (state == NORM) begin
            result_r <= norm_res;
         end
         if ((state == HOLD) && out_ready) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Self-checking bench for fp32_mul_seq: directed vectors, randomized operands against an
// arithmetic reference model, backpressure and mid-operation reset.
module tb_fp32_mul_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        busy;
   logic [15:0] done_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_cnt = '0;

   fp32_mul_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy),
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time=%0t limit=500000", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: full integer significand product, then the truncating normalize rules.
   function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      logic           s;
      int             ex, ey, e, sh;
      longint unsigned fx, fy, p;
      bit             nx, ny, ix, iy, zx, zy;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      fx = longint'(x[22:0]);
      fy = longint'(y[22:0]);
      nx = (ex == 255) && (fx != 0);
      ny = (ey == 255) && (fy != 0);
      ix = (ex == 255) && (fx == 0);
      iy = (ey == 255) && (fy == 0);
      zx = (ex == 0);
      zy = (ey == 0);
      if (nx || ny) return 32'h7FC00000;
      if ((ix && zy) || (iy && zx)) return 32'h7FC00000;
      if (ix || iy) return {s, 8'hFF, 23'd0};
      if (zx || zy) return {s, 31'd0};
      p = (fx + (64'd1 << 23)) * (fy + (64'd1 << 23));
      e = ex + ey - 127;
      if (p >= (64'd1 << 47)) begin
         p = p / 2;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) begin
         sh = 1 - e;
         if (sh >= 48) return {s, 31'd0};
         p = p >> sh;
         return {s, 8'd0, 23'(p >> 23)};
      end
      return {s, 8'(e), 23'(p >> 23)};
   endfunction

   function automatic bit ref_special(input logic [31:0] x, input logic [31:0] y);
      return (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF) || (x[30:23] == 8'h00) || (y[30:23] == 8'h00);
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] v;
      int          r;
      v = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) v[30:23] = 8'h00;
      else if (r == 1) begin
         v[30:23] = 8'hFF;
         if ($urandom_range(0, 1) == 0) v[22:0] = '0;
      end else v[30:23] = 8'($urandom_range(1, 254));
      return v;
   endfunction

   // Drives one operand pair; lat counts clock edges after the accept edge until out_valid.
   // With noise set, in_valid/a/b/out_ready toggle while the block is busy.
   task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input bit noise,
                                output int lat, output bit got);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      in_valid = 1'b1;
      a = av;
      b = bv;
      @(negedge clk);
      in_valid = noise;
      a = $urandom;
      b = $urandom;
      lat = 0;
      while (!out_valid && lat < 60) begin
         if (noise) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         a = $urandom;
         b = $urandom;
         lat++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      got = out_valid;
   endtask

   task automatic doHandshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_done_cnt: got %0d expected 0", done_cnt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [31:0] va [8] = '{32'h40000000, 32'h3FC00000, 32'h7FC00001, 32'h7F800000,
                              32'hFF800000, 32'h7F000000, 32'h00800000, 32'h00800001};
      logic [31:0] vb [8] = '{32'h40400000, 32'h3FC00000, 32'h3F800000, 32'h00000000,
                              32'h40000000, 32'h7F000000, 32'h3F000000, 32'h00800001};
      logic [31:0] ve [8] = '{32'h40C00000, 32'h40100000, 32'h7FC00000, 32'h7FC00000,
                              32'hFF800000, 32'h7F800000, 32'h00400000, 32'h00000000};
      int          vl [8] = '{25, 25, 0, 0, 0, 25, 25, 25};
      int          lat;
      bit          got;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(va[i], vb[i], 1'b0, lat, got);
         checks++;
         if (!got || result !== ve[i]) begin
            errors++;
            $display("[TB] FAIL directed_result[%0d]: got %h (valid %b) expected %h", i, result, got, ve[i]);
         end
         checks++;
         if (lat != vl[i]) begin
            errors++;
            $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, vl[i]);
         end
         doHandshake();
         exp_cnt++;
         checks++;
         if (done_cnt !== exp_cnt || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL directed_done_cnt[%0d]: got %0d/valid %b expected %0d/valid 0", i, done_cnt, out_valid, exp_cnt);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] av, bv, ev;
      int          lat, el;
      bit          got, noise;
      for (int i = 0; i < 40; i++) begin
         av = rand_operand();
         bv = rand_operand();
         ev = ref_mul(av, bv);
         el = ref_special(av, bv) ? 0 : 25;
         noise = 1'($urandom_range(0, 1));
         applyStimulus(av, bv, noise, lat, got);
         checks++;
         if (!got || result !== ev) begin
            errors++;
            $display("[TB] FAIL random_result[%0d] %h*%h: got %h (valid %b) expected %h", i, av, bv, result, got, ev);
         end
         checks++;
         if (lat != el) begin
            errors++;
            $display("[TB] FAIL random_latency[%0d]: got %0d expected %0d", i, lat, el);
         end
         doHandshake();
         exp_cnt++;
         checks++;
         if (done_cnt !== exp_cnt) begin
            errors++;
            $display("[TB] FAIL random_done_cnt[%0d]: got %0d expected %0d", i, done_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] ev;
      int          lat;
      bit          got;
      ev = ref_mul(32'h3FC00000, 32'h40400000);
      applyStimulus(32'h3FC00000, 32'h40400000, 1'b0, lat, got);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || result !== ev) begin
            errors++;
            $display("[TB] FAIL hold_result[%0d]: got %h (valid %b) expected %h", i, result, out_valid, ev);
         end
         checks++;
         if (in_ready !== 1'b0 || busy !== 1'b1 || done_cnt !== exp_cnt) begin
            errors++;
            $display("[TB] FAIL hold_status[%0d]: got in_ready %b busy %b cnt %0d expected 0 1 %0d", i, in_ready, busy, done_cnt, exp_cnt);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      exp_cnt++;
      checks++;
      if (done_cnt !== exp_cnt || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL handshake_cnt: got %0d/valid %b expected %0d/valid 0", done_cnt, out_valid, exp_cnt);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL handshake_in_ready: got %b expected 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat;
      bit got;
      in_valid = 1'b1;
      a = 32'h3FC00000;
      b = 32'h3FC00000;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      exp_cnt = '0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_status: got valid %b busy %b in_ready %b expected 0 0 1", out_valid, busy, in_ready);
      end
      checks++;
      if (result !== 32'h0 || done_cnt !== 16'h0) begin
         errors++;
         $display("[TB] FAIL midreset_regs: got result %h cnt %0d expected 00000000 0", result, done_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(32'h40000000, 32'h40400000, 1'b0, lat, got);
      checks++;
      if (!got || result !== 32'h40C00000 || lat != 25) begin
         errors++;
         $display("[TB] FAIL after_reset_op: got %h lat %0d expected 40c00000 lat 25", result, lat);
      end
      doHandshake();
      exp_cnt++;
      checks++;
      if (done_cnt !== exp_cnt) begin
         errors++;
         $display("[TB] FAIL after_reset_cnt: got %0d expected %0d", done_cnt, exp_cnt);
      end
   endtask

   initial begin
      $display("[TB] starting fp32_mul_seq bench");
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
